data_mem_unit: RTL
==================

// Module: data_mem_unit
// PURPOSE
//  Data-memory stage sitting directly downstream of the single-cycle datapath: consumes ALU_result (byte address),
//  Wr_mem_data, func3 and control strobes; returns Rd_mem_data in the same cycle for write-back.
//  Holds a word RAM with byte/half/word access and sign/zero extension, plus a small MMIO block:
//  LED register, free-running cycle counter, timer compare with sticky hit/IRQ, and a sticky error/status register.
// PARAMETERS
//  DEPTH_WORDS  256           RAM depth in 32-bit words (RAM occupies bytes 0 .. 4*DEPTH_WORDS-1)
//  MMIO_BASE    32'h0000_1000 base byte address of MMIO window (4 words)
// PORTS
//  clk          in   1   system clock, all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  mem_addr     in   32  byte address (datapath ALU_result)
//  mem_wdata    in   32  store data (datapath Wr_mem_data)
//  func3        in   3   access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  MemRead      in   1   load strobe for this cycle
//  MemWrite     in   1   store strobe for this cycle
//  Rd_mem_data  out  32  load result, extended, combinational
//  led          out  16  LED register [15:0]
//  irq          out  1   equals status.timer_hit
// BEHAVIOUR
//  Reset: led=0, cycle_cnt=0, tcmp=0, status=0, irq=0; RAM contents NOT reset. Reset mid-operation clears
//   registers immediately (async); any store in progress that cycle is lost.
//  Reads: combinational, zero latency; Rd_mem_data=0 when MemRead=0.
//  Writes: take effect at the rising edge of the cycle in which MemWrite=1; visible to a read the next cycle.
//  MemRead and MemWrite both 1: store performed, Rd_mem_data returns the pre-store value.
//  Alignment: h needs addr[0]=0, w needs addr[1:0]=00; b always aligned.
//  RAM loads: b/h select lane by addr[1:0]; b/h sign-extend; bu/hu zero-extend; w unmodified.
//  RAM stores: sb writes byte lane addr[1:0] from wdata[7:0]; sh writes lane pair from wdata[15:0];
//   sw writes the full word; unselected bytes unchanged.
//  MMIO window (word offset addr[3:2], word-only, func3 must be 010):
//   +0x0 LED     RW  bits[15:0]; read upper bits 0
//   +0x4 CYCLE   RO  32-bit counter, +1 every cycle, wraps FFFF_FFFF->0; writes ignored
//   +0x8 TCMP    RW  32-bit compare value; 0 disables timer
//   +0xC STATUS  R/W1C  bit0 timer_hit, bit1 access_err, bit2 range_err; bits[31:3] read 0
//  timer_hit set on the edge where tcmp!=0 and cycle_cnt==tcmp; sticky until cleared.
//  access_err set on a strobed access that is misaligned, uses an illegal func3 (011,110,111; 100/101 on store),
//   or is non-word to MMIO: store suppressed, load returns 0.
//  range_err set on a strobed access outside both RAM and MMIO: store ignored, load returns 0.
//  Simultaneous W1C clear and new set of the same STATUS bit: set wins (bit stays 1).
//  STATUS write to a bit with wdata 0 leaves it unchanged; W1C to timer_hit drops irq the next cycle.
//  Address arithmetic: RAM index = addr[log2(4*DEPTH_WORDS)-1:2]; no aliasing, full 32-bit compare used.
// TESTING
//  1 sw 0x8000_00FF @0x10, then lb @0x10 -> 0xFFFF_FFFF; lbu @0x13 -> 0x0000_0080; lhu @0x12 -> 0x0000_8000.
//  2 sw 0x1122_3344 @0x20; sb 0xAB @0x21; lw @0x20 -> 0x1122_AB44; sh 0xBEEF @0x22 -> lw 0xBEEF_AB44.
//  3 lw @0x22 -> Rd_mem_data 0, STATUS=0x2, RAM unchanged; sw @0x2000 -> STATUS bit2=1; sw 0x6 @STATUS -> 0.
//  4 after reset, sw 5 @TCMP at cycle 2 -> irq rises after edge where CYCLE==5; W1C 0x1 -> irq 0 next cycle.
//  5 W1C to STATUS in the same cycle a misaligned sh occurs -> access_err remains 1.
//  6 sw 0xFFFF_ABCD @LED -> led=0xABCD, lw @LED -> 0x0000_ABCD; assert rst_n=0 mid-run -> led, CYCLE, irq =0 at once.

Source files
------------

// File: rtl/data_mem_unit_if.sv
// Load/store bus between the single-cycle datapath (master) and the data-memory stage (slave).
// Read data is combinational, so a load returns in the same cycle it is strobed.
interface data_mem_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  func3;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Rd_mem_data;

  modport master (
    output mem_addr, mem_wdata, func3, MemRead, MemWrite,
    input  Rd_mem_data
  );

  modport slave (
    input  mem_addr, mem_wdata, func3, MemRead, MemWrite,
    output Rd_mem_data
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data-memory stage: byte/half/word RAM with sign/zero-extended loads, plus a 4-word MMIO block
// (LED, free-running cycle counter, timer compare, sticky W1C status driving irq).
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_unit_if.slave       bus,
  output logic [15:0]          led,
  output logic                 irq
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_W    = IDX_W + 2;
  localparam logic [31:0] RAM_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;

  logic [31:0] ram [DEPTH_WORDS];

  logic [15:0] led_q,    led_d;
  logic [31:0] cycle_q,  cycle_d;
  logic [31:0] tcmp_q,   tcmp_d;
  logic [2:0]  status_q, status_d;

  logic             strobe_s, in_ram_s, in_mmio_s, misalign_s, illegal_s;
  logic             acc_err_s, rng_err_s, ok_s, hit_s, ram_we_s, mmio_we_s;
  logic [IDX_W-1:0] ram_idx_s;
  logic [31:0]      ram_word_s, ram_load_s, mmio_rd_s, wlane_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [3:0]       be_s;

  assign ram_idx_s  = bus.mem_addr[ADDR_W-1:2];
  assign ram_word_s = ram[ram_idx_s];

  // Address decode and error classification for the strobed access
  always_comb begin
    strobe_s  = bus.MemRead | bus.MemWrite;
    in_ram_s  = (bus.mem_addr < RAM_LIMIT);
    in_mmio_s = (bus.mem_addr >= MMIO_BASE) && (bus.mem_addr < (MMIO_BASE + 32'd16));
    case (bus.func3)
      F3_H, F3_HU: misalign_s = bus.mem_addr[0];
      F3_W:        misalign_s = (bus.mem_addr[1:0] != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
    case (bus.func3)
      F3_B, F3_H, F3_W: illegal_s = 1'b0;
      F3_BU, F3_HU:     illegal_s = bus.MemWrite;
      default:          illegal_s = 1'b1;
    endcase
    acc_err_s = strobe_s & (misalign_s | illegal_s | (in_mmio_s & (bus.func3 != F3_W)));
    rng_err_s = strobe_s & ~in_ram_s & ~in_mmio_s;
    ok_s      = ~acc_err_s & ~rng_err_s;
    ram_we_s  = bus.MemWrite & ok_s & in_ram_s & rst_n;
    mmio_we_s = bus.MemWrite & ok_s & in_mmio_s;
    hit_s     = (tcmp_q != 32'd0) && (cycle_q == tcmp_q);
  end

  // Lane selection and extension for loads, MMIO read mux
  always_comb begin
    case (bus.mem_addr[1:0])
      2'd0:    byte_s = ram_word_s[7:0];
      2'd1:    byte_s = ram_word_s[15:8];
      2'd2:    byte_s = ram_word_s[23:16];
      default: byte_s = ram_word_s[31:24];
    endcase
    half_s = bus.mem_addr[1] ? ram_word_s[31:16] : ram_word_s[15:0];
    case (bus.func3)
      F3_B:    ram_load_s = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ram_load_s = {24'd0, byte_s};
      F3_H:    ram_load_s = {{16{half_s[15]}}, half_s};
      F3_HU:   ram_load_s = {16'd0, half_s};
      F3_W:    ram_load_s = ram_word_s;
      default: ram_load_s = 32'd0;
    endcase
    case (bus.mem_addr[3:2])
      2'd0:    mmio_rd_s = {16'd0, led_q};
      2'd1:    mmio_rd_s = cycle_q;
      2'd2:    mmio_rd_s = tcmp_q;
      default: mmio_rd_s = {29'd0, status_q};
    endcase
    if (bus.MemRead && ok_s) begin
      bus.Rd_mem_data = in_ram_s ? ram_load_s : mmio_rd_s;
    end else begin
      bus.Rd_mem_data = 32'd0;
    end
  end

  // Store byte enables and replicated write data
  always_comb begin
    case (bus.func3)
      F3_B: begin
        be_s    = 4'b0001 << bus.mem_addr[1:0];
        wlane_s = {4{bus.mem_wdata[7:0]}};
      end
      F3_H: begin
        be_s    = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{bus.mem_wdata[15:0]}};
      end
      F3_W: begin
        be_s    = 4'b1111;
        wlane_s = bus.mem_wdata;
      end
      default: begin
        be_s    = 4'b0000;
        wlane_s = 32'd0;
      end
    endcase
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          ram[ram_idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
        end
      end
    end
  end

  // MMIO next state; new status events win over a same-cycle W1C
  always_comb begin
    led_d    = led_q;
    tcmp_d   = tcmp_q;
    cycle_d  = cycle_q + 32'd1;
    status_d = status_q;
    if (mmio_we_s) begin
      case (bus.mem_addr[3:2])
        2'd0:    led_d    = bus.mem_wdata[15:0];
        2'd2:    tcmp_d   = bus.mem_wdata;
        2'd3:    status_d = status_q & ~bus.mem_wdata[2:0];
        default: led_d    = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
    status_d = status_d | {rng_err_s, acc_err_s, hit_s};
  end

  // MMIO register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= 16'd0;
      cycle_q  <= 32'd0;
      tcmp_q   <= 32'd0;
      status_q <= 3'd0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      tcmp_q   <= tcmp_d;
      status_q <= status_d;
    end
  end

  assign led = led_q;
  assign irq = status_q[0];

endmodule
